lsu_mem_port: RTL

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_extend.sv | 27 ++
 rtl/lsu_mem_port.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, size codes and FSM encoding for the LSU memory port
//
// Purpose: common definitions imported by lsu_extend and lsu_mem_port.
// Contents: bus width, memory depth, access size codes, FSM states,
//           byte-count helper for a size code.
package lsu_pkg;

  localparam int BUS_WIDTH       = 32;
  localparam int MEM_VECTOR_SIZE = 256;

  typedef enum logic [1:0] {
    BYTE         = 2'b00,
    HALF_WORD    = 2'b01,
    WORD         = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    SPLIT  = 2'b10,
    RESP   = 2'b11
  } state_e;

  // Number of bytes touched by an access; the illegal code reports 4 but is
  // rejected by the error check before the count matters.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      BYTE:      size_bytes = 3'd1;
      HALF_WORD: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - combinational byte/half-word sign or zero extension
//
// Purpose: widen a right-justified byte or half word to the bus width.
// Ports:
//   data_i  in  BUS_WIDTH  right-justified raw data
//   size_i  in  2          size code (BYTE / HALF_WORD / WORD)
//   sext_i  in  1          1 = sign-extend, 0 = zero-extend
//   data_o  out BUS_WIDTH  extended data (WORD passes through unchanged)
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [BUS_WIDTH-1:0] data_i,
  input  logic [1:0]           size_i,
  input  logic                 sext_i,
  output logic [BUS_WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      BYTE:      data_o = {{(BUS_WIDTH-8){sext_i & data_i[7]}}, data_i[7:0]};
      HALF_WORD: data_o = {{(BUS_WIDTH-16){sext_i & data_i[15]}}, data_i[15:0]};
      default:   data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store unit port onto a 256-byte byte-addressed memory
//
// Purpose: accepts one load/store at a time, range/size checks it, performs an
// aligned single access or a byte-by-byte split access for misaligned half
// words and words, and returns a one-cycle response.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_we, req_addr, req_wdata  store flag, byte address, right-justified store data
//   req_size, req_sext           size code, load sign-extension select
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response pulse, load data, error flag
//   mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex  memory drive
//   mem_data_out                 combinational memory read data
module lsu_mem_port
  import lsu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  input  logic [1:0]           req_size,
  input  logic                 req_sext,
  output logic                 rsp_valid,
  output logic [BUS_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_data_in,
  output logic                 mem_wr_en,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex,
  input  logic [BUS_WIDTH-1:0] mem_data_out
);

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0] acc_q, acc_d;
  logic [1:0]           size_q, size_d;
  logic [1:0]           beat_q, beat_d;
  logic                 we_q, we_d;
  logic                 sext_q, sext_d;
  logic                 err_q, err_d;

  logic [2:0]           req_bytes;
  logic [BUS_WIDTH:0]   req_last;
  logic                 req_bad;
  logic                 req_misaligned;
  logic                 last_beat;
  logic [BUS_WIDTH-1:0] ext_data;

  // One extra bit keeps the end-address sum from wrapping near 2^32.
  assign req_bytes = size_bytes(req_size);
  assign req_last  = {1'b0, req_addr} + {{(BUS_WIDTH-2){1'b0}}, req_bytes} - 33'd1;
  assign req_bad   = (req_size == SIZE_ILLEGAL) ||
                     (req_last > 33'(MEM_VECTOR_SIZE - 1));
  assign req_misaligned = ((req_size == HALF_WORD) && req_addr[0]) ||
                          ((req_size == WORD) && (req_addr[1:0] != 2'b00));

  assign last_beat = (beat_q == ((size_q == WORD) ? 2'd3 : 2'd1));

  // Aligned loads arrive already extended by the memory; re-extending with the
  // same size/sext leaves them unchanged, so one path serves both cases.
  lsu_extend u_extend (
    .data_i (acc_q),
    .size_i (size_q),
    .sext_i (sext_q),
    .data_o (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    acc_d       = acc_q;
    size_d      = size_q;
    beat_d      = beat_q;
    we_d        = we_q;
    sext_d      = sext_q;
    err_d       = err_q;
    req_ready   = (state_q == IDLE) && rst;
    mem_address = '0;
    mem_data_in = '0;
    mem_wr_en   = 1'b0;
    mem_size    = WORD;
    mem_sz_ex   = 1'b0;
    rsp_valid   = (state_q == RESP);
    rsp_err     = (state_q == RESP) && err_q;
    rsp_rdata   = ((state_q == RESP) && !err_q && !we_q) ? ext_data : '0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          we_d    = req_we;
          sext_d  = req_sext;
          err_d   = req_bad;
          beat_d  = 2'd0;
          acc_d   = '0;
          if (req_bad)             state_d = RESP;
          else if (req_misaligned) state_d = SPLIT;
          else                     state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_address = addr_q;
        mem_data_in = wdata_q;
        mem_wr_en   = we_q && rst;
        mem_size    = size_q;
        mem_sz_ex   = sext_q;
        acc_d       = mem_data_out;
        state_d     = RESP;
      end
      SPLIT: begin
        // Beat i moves byte lane i, little-endian, as a plain byte access.
        mem_address = addr_q + {{(BUS_WIDTH-2){1'b0}}, beat_q};
        mem_data_in = {{(BUS_WIDTH-8){1'b0}}, wdata_q[{beat_q, 3'b000} +: 8]};
        mem_wr_en   = we_q && rst;
        mem_size    = BYTE;
        acc_d[{beat_q, 3'b000} +: 8] = mem_data_out[7:0];
        if (last_beat) begin
          beat_d  = 2'd0;
          state_d = RESP;
        end else begin
          beat_d  = beat_q + 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
      size_q  <= WORD;
      beat_q  <= 2'd0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acc_q   <= acc_d;
      size_q  <= size_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      err_q   <= err_d;
    end
  end

endmodule
